// File: rtl/vga_scan_dither.sv
// vga_scan_dither: parametrised VGA timing generator with an ordered-dither
// colour output stage.
//
// The H/V/frame counters and their strobes are exported so that effect logic
// can compute a colour. That colour arrives PIPE_DELAY clocks later on
// r_in/g_in/b_in. The per-pixel context (active, raw sync levels and low
// counter bits) is delayed by the same amount, so sync and blanking stay
// aligned with the colour. One output register then drives the pins.
//
// Optional feature: define VGA_TEMPORAL_DITHER_EN to invert the 8x4 Bayer
// matrix in x on odd frames (temporal dither). When it is undefined the
// pattern is static and frame[0] is not carried through the delay line.
//
// Ports:
//   clk48        pixel clock
//   rst_n        asynchronous active-low reset
//   frame_clear  sampled at the frame wrap; zeroes the frame counter
//   r_in/g_in/b_in  IN_BITS colour for the counters PIPE_DELAY clocks ago
//   h_count, v_count, frame  live counters
//   active, prefetch_stb, line_stb, frame_stb  combinational strobes
//   hsync, vsync  registered syncs, polarity set by HSYNC_NEG/VSYNC_NEG
//   r_out/g_out/b_out  registered dithered OUT_BITS colour
module vga_scan_dither #(
  parameter int H_DISPLAY  = 1220,
  parameter int H_FRONT    = 31,
  parameter int H_SYNC     = 183,
  parameter int H_BACK     = 92,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HSYNC_NEG  = 1,
  parameter int VSYNC_NEG  = 1,
  parameter int IN_BITS    = 6,
  parameter int OUT_BITS   = 2,
  parameter int PIPE_DELAY = 0,
  parameter int PREFETCH   = 16,
  parameter int FRAME_W    = 11
) (
  input  logic                clk48,
  input  logic                rst_n,
  input  logic                frame_clear,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  output logic [10:0]         h_count,
  output logic [9:0]          v_count,
  output logic [FRAME_W-1:0]  frame,
  output logic                active,
  output logic                prefetch_stb,
  output logic                line_stb,
  output logic                frame_stb,
  output logic                hsync,
  output logic                vsync,
  output logic [OUT_BITS-1:0] r_out,
  output logic [OUT_BITS-1:0] g_out,
  output logic [OUT_BITS-1:0] b_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [10:0] H_ACT    = 11'(H_DISPLAY);
  localparam logic [9:0]  V_ACT    = 10'(V_DISPLAY);
  localparam logic [10:0] H_PREF   = 11'(H_DISPLAY - PREFETCH);
  localparam logic        HS_ON    = (HSYNC_NEG != 0) ? 1'b0 : 1'b1;
  localparam logic        VS_ON    = (VSYNC_NEG != 0) ? 1'b0 : 1'b1;
  localparam int          SW       = IN_BITS + OUT_BITS + 1;
  localparam logic [SW-1:0] MULT   = SW'((1 << OUT_BITS) - 1);
`ifdef VGA_TEMPORAL_DITHER_EN
  localparam int DL_W = 9;
`else
  localparam int DL_W = 8;
`endif

  // Scales c by (2^OUT_BITS-1), adds the threshold and keeps the top bits.
  // The sum cannot reach 2^(IN_BITS+OUT_BITS), so no clamp is required.
  function automatic logic [OUT_BITS-1:0] dither_ch(
    input logic [IN_BITS-1:0] c,
    input logic [4:0]         b5
  );
    logic [IN_BITS-1:0] t;
    logic [SW-1:0]      sum;
    t   = IN_BITS'(b5) << (IN_BITS - 5);
    sum = SW'(c) * MULT + SW'(t);
    return sum[IN_BITS +: OUT_BITS];
  endfunction

  logic [10:0]        h_count_r;
  logic [9:0]         v_count_r;
  logic [FRAME_W-1:0] frame_r;
  logic               h_last_s, v_last_s;
  logic               hs_raw_s, vs_raw_s;
  logic [DL_W-1:0]    cur_s, dly_s;
  logic               dly_act_s, dly_hs_s, dly_vs_s, tflip_s;
  logic [2:0]         dly_h_s, i_s, x_s;
  logic [1:0]         dly_v_s;
  logic [4:0]         bayer_s;
  logic [OUT_BITS-1:0] r_out_r, g_out_r, b_out_r;
  logic               hsync_r, vsync_r;

  assign h_last_s = (h_count_r == H_LAST);
  assign v_last_s = (v_count_r == V_LAST);

  // Pixel, line and frame counters.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      h_count_r <= 11'd0;
      v_count_r <= 10'd0;
      frame_r   <= {FRAME_W{1'b0}};
    end else if (h_last_s) begin
      h_count_r <= 11'd0;
      if (v_last_s) begin
        v_count_r <= 10'd0;
        frame_r   <= frame_clear ? {FRAME_W{1'b0}}
                                 : frame_r + {{(FRAME_W-1){1'b0}}, 1'b1};
      end else begin
        v_count_r <= v_count_r + 10'd1;
      end
    end else begin
      h_count_r <= h_count_r + 11'd1;
    end
  end

  assign h_count      = h_count_r;
  assign v_count      = v_count_r;
  assign frame        = frame_r;
  assign active       = (h_count_r < H_ACT) && (v_count_r < V_ACT);
  assign prefetch_stb = (h_count_r == H_PREF);
  assign line_stb     = (h_count_r == H_ACT);
  assign frame_stb    = h_last_s && v_last_s;
  // Sync "asserted" flags, polarity is applied only at the output register.
  assign hs_raw_s     = (h_count_r >= HS_START) && (h_count_r < HS_END);
  assign vs_raw_s     = (v_count_r >= VS_START) && (v_count_r < VS_END);

`ifdef VGA_TEMPORAL_DITHER_EN
  assign cur_s   = {active, hs_raw_s, vs_raw_s, h_count_r[2:0], v_count_r[1:0], frame_r[0]};
  assign tflip_s = dly_s[0];
`else
  assign cur_s   = {active, hs_raw_s, vs_raw_s, h_count_r[2:0], v_count_r[1:0]};
  assign tflip_s = 1'b0;
`endif

  // Context delay line; an all-zero entry is blank with syncs deasserted.
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dly_s = cur_s;
    end else begin : g_dly
      logic [DL_W-1:0] pipe_r [PIPE_DELAY];
      // Shift the pixel context one stage per clock.
      always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE_DELAY; k++) pipe_r[k] <= {DL_W{1'b0}};
        end else begin
          pipe_r[0] <= cur_s;
          for (int k = 1; k < PIPE_DELAY; k++) pipe_r[k] <= pipe_r[k-1];
        end
      end
      assign dly_s = pipe_r[PIPE_DELAY-1];
    end
  endgenerate

  assign dly_act_s = dly_s[DL_W-1];
  assign dly_hs_s  = dly_s[DL_W-2];
  assign dly_vs_s  = dly_s[DL_W-3];
  assign dly_h_s   = dly_s[DL_W-4 -: 3];
  assign dly_v_s   = dly_s[DL_W-7 -: 2];

  // Bayer 8x4 threshold index from the delayed pixel position.
  always_comb begin
    i_s     = dly_h_s ^ {3{tflip_s}};
    x_s     = {i_s[2], i_s[1] ^ dly_v_s[1], i_s[0] ^ dly_v_s[0]};
    bayer_s = {x_s[0], i_s[0], x_s[1], i_s[1], x_s[2]};
  end

  // Output register: dithered colour, forced black while blanked, plus syncs.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_out_r <= {OUT_BITS{1'b0}};
      g_out_r <= {OUT_BITS{1'b0}};
      b_out_r <= {OUT_BITS{1'b0}};
      hsync_r <= ~HS_ON;
      vsync_r <= ~VS_ON;
    end else begin
      if (dly_act_s) begin
        r_out_r <= dither_ch(r_in, bayer_s);
        g_out_r <= dither_ch(g_in, bayer_s);
        b_out_r <= dither_ch(b_in, bayer_s);
      end else begin
        r_out_r <= {OUT_BITS{1'b0}};
        g_out_r <= {OUT_BITS{1'b0}};
        b_out_r <= {OUT_BITS{1'b0}};
      end
      hsync_r <= dly_hs_s ? HS_ON : ~HS_ON;
      vsync_r <= dly_vs_s ? VS_ON : ~VS_ON;
    end
  end

  assign r_out = r_out_r;
  assign g_out = g_out_r;
  assign b_out = b_out_r;
  assign hsync = hsync_r;
  assign vsync = vsync_r;

endmodule
